// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
//   pll_state_e : sequencer FSM state encoding
//   cnt_w()     : register width needed to hold values 0..max_val
//   MAX_NUM_PLL : largest supported channel count
package pll_seq_pkg;

  localparam int MAX_NUM_PLL = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET_PLL = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAILED    = 3'd5
  } pll_state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// NUM_PLL x SYNC_STAGES bit-synchroniser array for the raw PLL locked inputs.
// Ports:
//   clk_i   : reference clock
//   rst_i   : asynchronous active-high reset, clears every stage to 0
//   async_i : raw asynchronous locked inputs
//   sync_o  : synchronised locked bits, SYNC_STAGES cycles behind async_i
module pll_lock_sync #(
  parameter int NUM_PLL     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_PLL-1:0] async_i,
  output logic [NUM_PLL-1:0] sync_o
);

  logic [SYNC_STAGES-1:0][NUM_PLL-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Multi-PLL reset/lock sequencer on the shared reference clock.
// Ports:
//   refclk          : reference clock
//   rst             : asynchronous active-high reset
//   enable_mask     : 1 = channel participates (registered internally)
//   locked_i        : raw asynchronous PLL locked signals
//   restart_i       : one-cycle pulse, leaves FAILED
//   clear_stats     : zeroes lock_loss_count on the next cycle
//   pll_rst_o       : reset to each PLL
//   domain_rst_o    : per-domain reset request (consumer synchronises)
//   ready_o         : all enabled PLLs locked and released
//   fail_o          : retries exhausted
//   retry_count     : retries in the current acquisition
//   lock_loss_count : saturating count of lock losses seen in RUN
//
// state     | meaning
// IDLE      | no channel enabled, everything held in reset
// RESET_PLL | enabled PLLs held in reset for RST_PULSE_CYCLES
// WAIT_LOCK | PLL resets released, waiting for lock_all or timeout
// STABLE    | lock_all seen, counting LOCK_STABLE_CYCLES consecutive cycles
// RUN       | domains released, ready_o high
// FAILED    | retries exhausted, waiting for restart_i
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_PLL             = 2,
  parameter int SYNC_STAGES         = 2,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 7,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic [NUM_PLL-1:0]    enable_mask,
  input  logic [NUM_PLL-1:0]    locked_i,
  input  logic                  restart_i,
  input  logic                  clear_stats,
  output logic [NUM_PLL-1:0]    pll_rst_o,
  output logic [NUM_PLL-1:0]    domain_rst_o,
  output logic                  ready_o,
  output logic                  fail_o,
  output logic [3:0]            retry_count,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  // One timer serves both the reset pulse and the lock timeout; it is a
  // down-counter loaded on state entry and exits the state at zero.
  localparam int TMR_MAX = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           RST_PULSE_CYCLES - 1 : LOCK_TIMEOUT_CYCLES - 1;
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam int STB_W   = cnt_w(LOCK_STABLE_CYCLES - 1);

  localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LOAD = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  pll_state_e              state_q, state_d;
  logic [NUM_PLL-1:0]      mask_q;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [STB_W-1:0]        stab_q, stab_d;
  logic [3:0]              retry_q, retry_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic [NUM_PLL-1:0]      pll_rst_q, pll_rst_d;
  logic [NUM_PLL-1:0]      dom_rst_q, dom_rst_d;
  logic                    ready_q, ready_d;
  logic                    fail_q, fail_d;

  logic [NUM_PLL-1:0]      lock_sync;
  logic                    lock_all;
  logic                    mask_chg;
  logic                    loss_inc;

  pll_lock_sync #(
    .NUM_PLL    (NUM_PLL),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (refclk),
    .rst_i  (rst),
    .async_i(locked_i),
    .sync_o (lock_sync)
  );

  assign lock_all = &(lock_sync | ~mask_q);
  assign mask_chg = (enable_mask != mask_q);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stab_d   = stab_q;
    retry_d  = retry_q;
    loss_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (mask_q != '0) begin
          state_d = RESET_PLL;
          timer_d = RST_LOAD;
        end
      end
      RESET_PLL: begin
        if (timer_q == '0) begin
          state_d = WAIT_LOCK;
          timer_d = TMO_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WAIT_LOCK: begin
        // lock_all is tested first so it wins over a coincident timeout
        if (lock_all) begin
          state_d = STABLE;
          stab_d  = STB_LOAD;
        end else if (timer_q == '0) begin
          if (retry_q == RETRY_MAX) begin
            state_d = FAILED;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = RESET_PLL;
            timer_d = RST_LOAD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      STABLE: begin
        if (!lock_all) begin
          state_d = WAIT_LOCK;
          timer_d = TMO_LOAD;
        end else if (stab_q == '0) begin
          state_d = RUN;
        end else begin
          stab_d = stab_q - 1'b1;
        end
      end
      RUN: begin
        if (!lock_all) begin
          state_d  = RESET_PLL;
          timer_d  = RST_LOAD;
          retry_d  = '0;
          loss_inc = 1'b1;
        end
      end
      FAILED: begin
        if (restart_i) begin
          state_d = RESET_PLL;
          timer_d = RST_LOAD;
          retry_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new channel set invalidates whatever acquisition was in progress.
    if (mask_chg && state_q != IDLE && state_q != FAILED) begin
      state_d  = RESET_PLL;
      timer_d  = RST_LOAD;
      retry_d  = '0;
      loss_inc = 1'b0;
    end

    // With no channel enabled lock_all would be vacuously true, so park in IDLE.
    if (enable_mask == '0 && state_d != FAILED) begin
      state_d = IDLE;
    end

    loss_d = loss_q;
    if (clear_stats) begin
      loss_d = '0;
    end else if (loss_inc && loss_q != '1) begin
      loss_d = loss_q + 1'b1;
    end

    // Outputs are decoded from the next state and next mask so that the
    // output registers line up with the state register.
    pll_rst_d = '1;
    dom_rst_d = '1;
    if (state_d == WAIT_LOCK || state_d == STABLE || state_d == RUN) begin
      pll_rst_d = ~enable_mask;
    end
    if (state_d == RUN) begin
      dom_rst_d = ~enable_mask;
    end
    ready_d = (state_d == RUN);
    fail_d  = (state_d == FAILED);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      timer_q   <= '0;
      stab_q    <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= '1;
      dom_rst_q <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= enable_mask;
      timer_q   <= timer_d;
      stab_q    <= stab_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      dom_rst_q <= dom_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign domain_rst_o    = dom_rst_q;
  assign ready_o         = ready_q;
  assign fail_o          = fail_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus pushes cycle-stamped
// expectations, a monitor pops and compares them on the falling edge.
module tb_pll_lock_sequencer;

  localparam int SEL_PLL   = 0;
  localparam int SEL_DOM   = 1;
  localparam int SEL_RDY   = 2;
  localparam int SEL_FAIL  = 3;
  localparam int SEL_RETRY = 4;
  localparam int SEL_LOSS  = 5;

  logic       refclk;
  logic       rst;
  logic [1:0] enable_mask;
  logic [1:0] locked_i;
  logic       restart_i;
  logic       clear_stats;
  logic [1:0] pll_rst_o;
  logic [1:0] domain_rst_o;
  logic       ready_o;
  logic       fail_o;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  pll_lock_sequencer #(
    .NUM_PLL            (2),
    .SYNC_STAGES        (2),
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2),
    .LOSS_CNT_W         (8)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .enable_mask    (enable_mask),
    .locked_i       (locked_i),
    .restart_i      (restart_i),
    .clear_stats    (clear_stats),
    .pll_rst_o      (pll_rst_o),
    .domain_rst_o   (domain_rst_o),
    .ready_o        (ready_o),
    .fail_o         (fail_o),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string name;
  } chk_t;

  chk_t sb_q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  function automatic int observe(input int sel);
    case (sel)
      SEL_PLL:   return int'(pll_rst_o);
      SEL_DOM:   return int'(domain_rst_o);
      SEL_RDY:   return int'(ready_o);
      SEL_FAIL:  return int'(fail_o);
      SEL_RETRY: return int'(retry_count);
      SEL_LOSS:  return int'(lock_loss_count);
      default:   return -1;
    endcase
  endfunction

  task automatic exp_at(input int d, input int sel, input int v, input string nm);
    chk_t c;
    int   idx;
    c.cyc  = cyc + d;
    c.sel  = sel;
    c.exp  = v;
    c.name = nm;
    idx = sb_q.size();
    while (idx > 0 && sb_q[idx-1].cyc > c.cyc) idx--;
    sb_q.insert(idx, c);
  endtask

  task automatic exp_outs(input int d, input int pll, input int dom, input int rdy,
                          input int fl, input string nm);
    exp_at(d, SEL_PLL,  pll, {nm, ".pll_rst"});
    exp_at(d, SEL_DOM,  dom, {nm, ".domain_rst"});
    exp_at(d, SEL_RDY,  rdy, {nm, ".ready"});
    exp_at(d, SEL_FAIL, fl,  {nm, ".fail"});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic start_seq(input logic [1:0] lk);
    rst         = 1'b1;
    enable_mask = 2'b00;
    locked_i    = lk;
    restart_i   = 1'b0;
    clear_stats = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Monitor
  initial begin
    chk_t c;
    int   act;
    forever begin
      @(negedge refclk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        c   = sb_q.pop_front();
        act = observe(c.sel);
        n_total++;
        if (act == c.exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", c.name, cyc, act, c.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst         = 1'b1;
    enable_mask = 2'b00;
    locked_i    = 2'b00;
    restart_i   = 1'b0;
    clear_stats = 1'b0;
    tick(1);
    exp_outs(1, 3, 3, 0, 0, "reset");
    exp_at(1, SEL_RETRY, 0, "reset.retry");
    exp_at(1, SEL_LOSS,  0, "reset.loss");
    tick(2);

    // 1. nominal lock
    start_seq(2'b00);
    enable_mask = 2'b11;
    exp_at(5, SEL_PLL, 3, "nom.pll_rst_last_pulse");
    exp_at(6, SEL_PLL, 0, "nom.pll_rst_released");
    exp_at(6, SEL_RDY, 0, "nom.ready_wait");
    tick(16);
    locked_i = 2'b11;
    exp_at(10, SEL_RDY, 0, "nom.ready_early");
    exp_outs(11, 0, 0, 1, 0, "nom.run");
    exp_at(11, SEL_RETRY, 0, "nom.retry");
    tick(12);

    // 2. glitch on locked_i[1] at stable count 5
    start_seq(2'b00);
    enable_mask = 2'b11;
    tick(16);
    locked_i = 2'b11;
    exp_at(11, SEL_RDY, 0, "glitch.ready_nominal_slot");
    tick(6);
    locked_i = 2'b01;
    tick(1);
    locked_i = 2'b11;
    exp_at(2,  SEL_PLL,   0, "glitch.pll_rst_no_retry");
    exp_at(10, SEL_RDY,   0, "glitch.ready_early");
    exp_at(11, SEL_RDY,   1, "glitch.ready");
    exp_at(11, SEL_RETRY, 0, "glitch.retry");
    tick(12);

    // 3. timeout and fail
    start_seq(2'b00);
    enable_mask = 2'b11;
    exp_at(37,  SEL_RETRY, 0, "tmo.retry0");
    exp_at(37,  SEL_PLL,   0, "tmo.win0_pll");
    exp_at(38,  SEL_RETRY, 1, "tmo.retry1");
    exp_at(38,  SEL_PLL,   3, "tmo.repulse1");
    exp_at(73,  SEL_RETRY, 1, "tmo.retry1_hold");
    exp_at(74,  SEL_RETRY, 2, "tmo.retry2");
    exp_at(109, SEL_FAIL,  0, "tmo.fail_early");
    exp_at(109, SEL_PLL,   0, "tmo.win2_pll");
    exp_outs(110, 3, 3, 0, 1, "tmo.failed");
    exp_at(115, SEL_FAIL,  1, "tmo.fail_held");
    exp_at(115, SEL_RETRY, 2, "tmo.retry_held");
    tick(115);
    restart_i = 1'b1;
    exp_at(1, SEL_FAIL,  0, "restart.fail");
    exp_at(1, SEL_RETRY, 0, "restart.retry");
    exp_at(1, SEL_PLL,   3, "restart.pll_rst");
    exp_at(4, SEL_PLL,   3, "restart.pll_rst_end");
    exp_at(5, SEL_PLL,   0, "restart.pll_rel");
    tick(1);
    restart_i = 1'b0;
    tick(5);
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    exp_at(1, SEL_PLL,   0, "restart_ignored.pll");
    exp_at(1, SEL_RETRY, 0, "restart_ignored.retry");
    tick(3);

    // 4. lock loss in RUN, saturation, clear collision
    start_seq(2'b11);
    enable_mask = 2'b11;
    exp_at(14, SEL_RDY, 0, "loss.pre_run");
    exp_outs(15, 0, 0, 1, 0, "loss.run");
    exp_at(15, SEL_LOSS, 0, "loss.count0");
    tick(20);
    locked_i = 2'b10;
    exp_at(2, SEL_RDY,   1, "loss.ready_still");
    exp_outs(3, 3, 3, 0, 0, "loss.drop");
    exp_at(3, SEL_LOSS,  1, "loss.count1");
    exp_at(3, SEL_RETRY, 0, "loss.retry");
    tick(3);
    locked_i = 2'b11;
    exp_at(12, SEL_RDY,  0, "reacq.early");
    exp_at(13, SEL_RDY,  1, "reacq.ready");
    exp_at(13, SEL_LOSS, 1, "reacq.count");
    tick(13);
    for (int i = 1; i <= 255; i++) begin
      locked_i = 2'b10;
      exp_at(3, SEL_LOSS, (i + 1 > 255) ? 255 : i + 1, $sformatf("sat.loss%0d", i + 1));
      tick(3);
      locked_i = 2'b11;
      tick(13);
    end
    locked_i = 2'b10;
    tick(2);
    clear_stats = 1'b1;
    exp_at(1, SEL_LOSS, 0, "clear_vs_loss");
    tick(1);
    clear_stats = 1'b0;
    locked_i = 2'b11;
    exp_at(13, SEL_RDY, 1, "clear.reacq");
    tick(13);
    locked_i = 2'b10;
    exp_at(3, SEL_LOSS, 1, "clear.next_loss");
    tick(3);
    locked_i = 2'b11;
    tick(2);

    // 5. mask handling
    start_seq(2'b01);
    exp_outs(5, 3, 3, 0, 0, "idle_mask0");
    tick(6);
    enable_mask = 2'b01;
    exp_at(6, SEL_PLL, 2, "mask01.wait_pll");
    exp_outs(15, 2, 2, 1, 0, "mask01.run");
    tick(17);
    enable_mask = 2'b11;
    exp_outs(1, 3, 3, 0, 0, "mask11.restart");
    exp_at(1, SEL_RETRY, 0, "mask11.retry");
    exp_at(1, SEL_LOSS,  0, "mask11.loss");
    exp_at(4, SEL_PLL,   3, "mask11.pulse_end");
    exp_at(5, SEL_PLL,   0, "mask11.pll_rel");
    tick(7);
    enable_mask = 2'b00;
    exp_outs(1, 3, 3, 0, 0, "mask00.idle");
    exp_outs(6, 3, 3, 0, 0, "mask00.idle_hold");
    tick(8);

    // 6. asynchronous reset in STABLE
    start_seq(2'b11);
    enable_mask = 2'b11;
    exp_at(9, SEL_PLL, 0, "areset.before");
    exp_at(9, SEL_RDY, 0, "areset.before_rdy");
    tick(9);
    @(posedge refclk);
    #1;
    exp_outs(0, 3, 3, 0, 0, "areset");
    exp_at(0, SEL_RETRY, 0, "areset.retry");
    exp_at(0, SEL_LOSS,  0, "areset.loss");
    rst = 1'b1;
    #1;
    n_total++;
    if (pll_rst_o == 2'b11) n_pass++;
    else $display("FAIL areset.direct.pll_rst: got %0d, expected 3", pll_rst_o);
    n_total++;
    if (domain_rst_o == 2'b11) n_pass++;
    else $display("FAIL areset.direct.domain_rst: got %0d, expected 3", domain_rst_o);
    n_total++;
    if (ready_o == 1'b0) n_pass++;
    else $display("FAIL areset.direct.ready: got %0d, expected 0", ready_o);
    n_total++;
    if (fail_o == 1'b0) n_pass++;
    else $display("FAIL areset.direct.fail: got %0d, expected 0", fail_o);
    n_total++;
    if (retry_count == 4'd0) n_pass++;
    else $display("FAIL areset.direct.retry: got %0d, expected 0", retry_count);
    n_total++;
    if (lock_loss_count == 8'd0) n_pass++;
    else $display("FAIL areset.direct.loss: got %0d, expected 0", lock_loss_count);
    tick(2);
    rst = 1'b0;
    tick(2);
    #1;

    while (sb_q.size() > 0) begin
      chk_t c;
      c = sb_q.pop_front();
      n_total++;
      $display("FAIL %s not reached: got none, expected %0d", c.name, c.exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Multi-PLL reset/lock sequencer running on the shared reference clock. It drives the reset of up to NUM_PLL PLL instances and qualifies their `locked` outputs through synchronisers and a stability filter. Once every enabled PLL has locked it releases per-domain reset requests, and on lock loss or timeout it retries and reports status. It generalises the single-PLL rst/locked pairing with channel count, retry, timeout and lock-loss accounting.

Parameters:
- NUM_PLL, 2, number of PLL channels (1..8).
- SYNC_STAGES, 2, synchroniser depth on locked_i (>=2).
- RST_PULSE_CYCLES, 16, PLL reset pulse length in refclk cycles (>=1).
- LOCK_STABLE_CYCLES, 1024, consecutive all-locked cycles required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 100000, maximum cycles in WAIT_LOCK per attempt (>=2).
- MAX_RETRIES, 7, retries allowed before FAILED (0..15).
- LOSS_CNT_W, 8, width of lock_loss_count.

Ports:
- refclk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- enable_mask, in, NUM_PLL, 1 = channel participates.
- locked_i, in, NUM_PLL, raw PLL locked signals, asynchronous.
- restart_i, in, 1, one-cycle pulse; leaves FAILED.
- clear_stats, in, 1, zeroes lock_loss_count.
- pll_rst_o, out, NUM_PLL, reset to each PLL.
- domain_rst_o, out, NUM_PLL, per-domain reset request; the consuming domain synchronises it.
- ready_o, out, 1, all enabled PLLs locked and released.
- fail_o, out, 1, retries exhausted.
- retry_count, out, 4, retries in the current acquisition.
- lock_loss_count, out, LOSS_CNT_W, saturating count of lock-loss events in RUN.

Behaviour:
- Reset values:
  - pll_rst_o = all 1; domain_rst_o = all 1.
  - ready_o = 0; fail_o = 0.
  - retry_count = 0; lock_loss_count = 0.
  - Synchronisers = 0; state = IDLE.
- All outputs are registered.
- Lock qualification:
  - locked_sync = locked_i through SYNC_STAGES flops.
  - lock_all = &(locked_sync | ~enable_mask).
  - Latency from a locked_i edge to lock_all is SYNC_STAGES cycles.
- Disabled channels: pll_rst_o and domain_rst_o are held at 1 in every state.
- Mask changes: enable_mask is registered. Any change seen outside IDLE/FAILED forces RESET_PLL, with retry_count = 0 and ready_o = 0 on the next cycle.
- IDLE:
  - Stays here while enable_mask == 0.
  - A non-zero mask moves to RESET_PLL.
- RESET_PLL:
  - Enabled pll_rst_o = 1 for exactly RST_PULSE_CYCLES cycles, then WAIT_LOCK.
  - The timer clears on entry.
- WAIT_LOCK:
  - Enabled pll_rst_o = 0; the timer counts up.
  - If lock_all: go to STABLE and clear the stability counter.
  - Otherwise, when the timer reaches LOCK_TIMEOUT_CYCLES-1:
    - if retry_count == MAX_RETRIES, go to FAILED;
    - else increment retry_count and go to RESET_PLL.
  - If lock_all and the timeout coincide in the same cycle, lock_all wins.
- STABLE:
  - lock_all deasserting returns to WAIT_LOCK with the timer cleared; the retry is not counted.
  - After LOCK_STABLE_CYCLES consecutive cycles with lock_all, go to RUN.
- RUN:
  - On the first RUN cycle, enabled domain_rst_o = 0 and ready_o = 1.
  - If lock_all drops:
    - next cycle: domain_rst_o = all 1, ready_o = 0;
    - lock_loss_count increments, saturating at all-ones;
    - retry_count clears; state goes to RESET_PLL.
- FAILED:
  - pll_rst_o = all 1; domain_rst_o = all 1; fail_o = 1; ready_o = 0.
  - Held until restart_i, which sets retry_count = 0 and fail_o = 0 and moves to RESET_PLL.
  - restart_i has no effect in any other state.
- clear_stats takes effect next cycle. If it coincides with a lock-loss increment, clear wins and the result is 0.
- Counter widths: $clog2(max value + 1). Timers never wrap; they are bounded by the state exits.
- Asserting rst mid-sequence returns every output to its reset value immediately (asynchronous).

Decomposition:
- Package pll_seq_pkg holds:
  - state enum {IDLE, RESET_PLL, WAIT_LOCK, STABLE, RUN, FAILED};
  - a counter-width function;
  - a MAX_NUM_PLL = 8 constant.
- One sub-module, pll_lock_sync: a parametrised NUM_PLL x SYNC_STAGES bit-synchroniser array with reset to 0.

Test Plan:
Configuration for all scenarios: NUM_PLL=2, SYNC_STAGES=2, RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Nominal lock:
   - Stimulus: mask=11 after rst; locked_i=11 raised 10 cycles after pll_rst_o falls.
   - Response: pll_rst_o=11 for 4 cycles; ready_o=1 and domain_rst_o=00 exactly 2+8 cycles after the lock edge (±1 for the register stage, checked exactly).
2. Lock glitch in STABLE:
   - Stimulus: locked_i[1] low for 1 cycle at stable count 5.
   - Response: retry_count stays 0; ready_o is delayed a further full 8 stable cycles.
3. Timeout/fail:
   - Stimulus: locked_i=00 throughout.
   - Response: 3 WAIT_LOCK windows of 32 cycles; retry_count steps 0→1→2; then fail_o=1 with pll_rst_o=11; restart_i pulse gives fail_o=0, retry_count=0, pll_rst_o pulses again.
4. Lock loss in RUN:
   - Stimulus: drop locked_i[0].
   - Response: domain_rst_o=11 and ready_o=0 within SYNC_STAGES+1 cycles; lock_loss_count=1; re-acquisition to ready_o=1.
   - Then force 255 further losses: count saturates at 255; clear_stats asserted in the same cycle as a loss gives 0.
5. Mask handling:
   - Stimulus: mask=01 with locked_i[1]=0.
   - Response: ready_o=1 with domain_rst_o=10 and pll_rst_o[1]=1.
   - Changing the mask to 11 in RUN gives ready_o=0 next cycle and a fresh RESET_PLL.
   - mask=00 leaves the block in IDLE with all outputs held in reset.
6. Async reset mid-STABLE: assert rst asynchronously between clock edges → all outputs return to reset values before the next refclk edge.
